// File: rtl/hbm_bench_sched.sv
// ---------------------------------------------------------------------------
// hbm_bench_sched
//
// Run-level controller for a bank of HBM read/write benchmark engines.
// The host issues one run command (parameter word + engine mask + launch
// mode). The block broadcasts the parameter word, launches the enabled
// engines one at a time (sequential mode) or all together (concurrent mode),
// collects their end_of_exec pulses, and merges one engine's latency samples
// into count/sum/min/max statistics. An optional watchdog aborts a run that
// takes too long.
//
// Ports
//   clk_i, rst_ni            engine clock, asynchronous active-low reset
//   host_start_i             one-cycle run request (ignored while busy)
//   host_params_i            parameter word for the run
//   host_mask_i              engines enabled for the run
//   host_concurrent_i        1 = launch all enabled engines together
//   busy_o                   run in progress
//   done_o                   one-cycle pulse at run end
//   timeout_err_o            watchdog fired; sticky until next accepted start
//   engines_done_o           engines whose end_of_exec was seen this run
//   total_cycles_o           number of busy cycles of the run
//   lat_count_o/lat_sum_o    merged latency sample count (saturating) / sum
//   lat_min_o/lat_max_o      merged latency minimum / maximum
//   eng_start_o              per-engine one-cycle start pulse
//   eng_params_o             registered parameter word for all engines
//   eng_end_of_exec_i        per-engine completion pulse
//   eng_lat_valid_i          per-engine latency sample strobe
//   eng_lat_timer_i          per-engine 16-bit samples, engine i at [16i+15:16i]
// ---------------------------------------------------------------------------
module hbm_bench_sched #(
   parameter int unsigned NUM_ENGINES    = 8,
   parameter int unsigned PARAMS_BITS    = 256,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       host_start_i,
   input  logic [PARAMS_BITS-1:0]     host_params_i,
   input  logic [NUM_ENGINES-1:0]     host_mask_i,
   input  logic                       host_concurrent_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       timeout_err_o,
   output logic [NUM_ENGINES-1:0]     engines_done_o,
   output logic [63:0]                total_cycles_o,
   output logic [31:0]                lat_count_o,
   output logic [63:0]                lat_sum_o,
   output logic [15:0]                lat_min_o,
   output logic [15:0]                lat_max_o,
   output logic [NUM_ENGINES-1:0]     eng_start_o,
   output logic [PARAMS_BITS-1:0]     eng_params_o,
   input  logic [NUM_ENGINES-1:0]     eng_end_of_exec_i,
   input  logic [NUM_ENGINES-1:0]     eng_lat_valid_i,
   input  logic [16*NUM_ENGINES-1:0]  eng_lat_timer_i
);

   localparam int unsigned IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_NEXT,
      S_DONE
   } state_e;

   // Index of the lowest set bit (0 when the vector is empty).
   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_ENGINES-1:0] v);
      lowest_set = '0;
      for (int i = int'(NUM_ENGINES) - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = IDX_W'(i);
      end
   endfunction

   state_e                   state_q, state_d;
   logic [NUM_ENGINES-1:0]   pending_q, pending_d;
   logic [NUM_ENGINES-1:0]   mask_q, mask_d;
   logic                     mode_q, mode_d;
   // Latency source engine: the engine being run in sequential mode, the
   // probe (lowest enabled engine) in concurrent mode.
   logic [IDX_W-1:0]         cur_q, cur_d;
   logic [PARAMS_BITS-1:0]   params_q, params_d;
   logic [NUM_ENGINES-1:0]   eng_start_q, eng_start_d;
   logic [NUM_ENGINES-1:0]   engines_done_q, engines_done_d;
   logic                     timeout_err_q, timeout_err_d;
   logic [63:0]              total_cycles_q, total_cycles_d;
   logic [31:0]              lat_count_q, lat_count_d;
   logic [63:0]              lat_sum_q, lat_sum_d;
   logic [15:0]              lat_min_q, lat_min_d;
   logic [15:0]              lat_max_q, lat_max_d;

   logic                     busy;
   logic                     wd_hit;
   logic [NUM_ENGINES-1:0]   new_ends;
   logic [15:0]              src_sample;
   logic [15:0]              lat_sample [NUM_ENGINES];

   for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_lat_split
      assign lat_sample[gi] = eng_lat_timer_i[16*gi +: 16];
   end

   assign busy       = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_NEXT);
   assign new_ends   = eng_end_of_exec_i & mask_q;
   assign src_sample = lat_sample[cur_q];

   // total_cycles counts from S_LAUNCH entry, so it doubles as the watchdog
   // counter: the limit is reached on the cycle this count would hit it.
   assign wd_hit = (TIMEOUT_CYCLES != 32'd0) &&
                   ((total_cycles_q + 64'd1) >= {32'd0, TIMEOUT_CYCLES});

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      pending_d      = pending_q;
      mask_d         = mask_q;
      mode_d         = mode_q;
      cur_d          = cur_q;
      params_d       = params_q;
      eng_start_d    = '0;
      engines_done_d = engines_done_q;
      timeout_err_d  = timeout_err_q;
      total_cycles_d = total_cycles_q;
      lat_count_d    = lat_count_q;
      lat_sum_d      = lat_sum_q;
      lat_min_d      = lat_min_q;
      lat_max_d      = lat_max_q;

      if (busy) begin
         total_cycles_d = total_cycles_q + 64'd1;
         if (eng_lat_valid_i[cur_q]) begin
            if (lat_count_q != 32'hFFFF_FFFF) lat_count_d = lat_count_q + 32'd1;
            lat_sum_d = lat_sum_q + {48'd0, src_sample};
            if (src_sample < lat_min_q) lat_min_d = src_sample;
            if (src_sample > lat_max_q) lat_max_d = src_sample;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (host_start_i) begin
               params_d       = host_params_i;
               pending_d      = host_mask_i;
               mask_d         = host_mask_i;
               mode_d         = host_concurrent_i;
               cur_d          = lowest_set(host_mask_i);
               engines_done_d = '0;
               timeout_err_d  = 1'b0;
               total_cycles_d = '0;
               lat_count_d    = '0;
               lat_sum_d      = '0;
               lat_max_d      = '0;
               lat_min_d      = 16'hFFFF;
               if (host_mask_i == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d     = S_LAUNCH;
                  eng_start_d = host_concurrent_i ? host_mask_i
                                                  : (NUM_ENGINES'(1) << cur_d);
               end
            end
         end
         S_LAUNCH: begin
            if (wd_hit) begin
               state_d       = S_DONE;
               timeout_err_d = 1'b1;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            engines_done_d = engines_done_q | new_ends;
            pending_d      = pending_q & ~new_ends;
            // Completion is checked before the watchdog so it wins a tie.
            if (mode_q && ((engines_done_q | new_ends) == mask_q)) begin
               state_d = S_DONE;
            end else if (!mode_q && new_ends[cur_q]) begin
               state_d = S_NEXT;
            end else if (wd_hit) begin
               state_d       = S_DONE;
               timeout_err_d = 1'b1;
            end
         end
         S_NEXT: begin
            if (pending_q == '0) begin
               state_d = S_DONE;
            end else if (wd_hit) begin
               state_d       = S_DONE;
               timeout_err_d = 1'b1;
            end else begin
               state_d     = S_LAUNCH;
               cur_d       = lowest_set(pending_q);
               eng_start_d = NUM_ENGINES'(1) << cur_d;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q      <= '0;
         mask_q         <= '0;
         mode_q         <= 1'b0;
         cur_q          <= '0;
         params_q       <= '0;
         eng_start_q    <= '0;
         engines_done_q <= '0;
         timeout_err_q  <= 1'b0;
         total_cycles_q <= '0;
         lat_count_q    <= '0;
         lat_sum_q      <= '0;
         lat_min_q      <= 16'hFFFF;
         lat_max_q      <= '0;
      end else begin
         pending_q      <= pending_d;
         mask_q         <= mask_d;
         mode_q         <= mode_d;
         cur_q          <= cur_d;
         params_q       <= params_d;
         eng_start_q    <= eng_start_d;
         engines_done_q <= engines_done_d;
         timeout_err_q  <= timeout_err_d;
         total_cycles_q <= total_cycles_d;
         lat_count_q    <= lat_count_d;
         lat_sum_q      <= lat_sum_d;
         lat_min_q      <= lat_min_d;
         lat_max_q      <= lat_max_d;
      end
   end

   assign busy_o         = busy;
   assign done_o         = (state_q == S_DONE);
   assign timeout_err_o  = timeout_err_q;
   assign engines_done_o = engines_done_q;
   assign total_cycles_o = total_cycles_q;
   assign lat_count_o    = lat_count_q;
   assign lat_sum_o      = lat_sum_q;
   assign lat_min_o      = lat_min_q;
   assign lat_max_o      = lat_max_q;
   assign eng_start_o    = eng_start_q;
   assign eng_params_o   = params_q;

endmodule
